// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-addressed instruction memory with a streaming loader and a
// combinational multi-byte fetch window.
//
// A load is requested with a one-cycle load_start_i pulse carrying a base
// address and a byte count. Requests that are empty or run past the end of
// memory are rejected. Rejection raises the sticky load_err_o flag and writes
// nothing. Accepted requests consume bytes through a valid/ready handshake.
// Each accepted byte is written at an incrementing pointer. One cycle after
// the last byte, load_done_o pulses.
//
// The fetch port returns INSTR_BYTES consecutive bytes starting at PC_i,
// with the lowest address in the least significant byte. Window bytes that
// fall at or beyond the end of memory read as zero. The window is flagged
// invalid while a load is in progress or when it does not fit in memory.
// Memory contents are not affected by reset.
//
// Parameters
//   MEM_BYTES    size of the instruction memory in bytes
//   INSTR_BYTES  width of the fetch window in bytes
//
// Ports
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous active-high reset (control state only)
//   load_start_i  one-cycle load request, honoured only when idle
//   load_base_i   first byte address of the load
//   load_len_i    number of bytes to load (1..MEM_BYTES)
//   byte_valid_i  a program byte is offered
//   byte_data_i   the offered program byte
//   byte_ready_o  loader accepts a byte this cycle
//   load_busy_o   a load is in progress (LOAD or DONE)
//   load_done_o   one-cycle pulse after the last byte is written
//   load_err_o    sticky: the last requested load was rejected
//   PC_i          fetch address
//   instr_o       bytes PC_i+INSTR_BYTES-1 .. PC_i, byte PC_i in [7:0]
//   imem_error_o  fetch window invalid
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_BYTES   = 1024,
  parameter int INSTR_BYTES = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_start_i,
  input  logic [9:0]               load_base_i,
  input  logic [10:0]              load_len_i,
  input  logic                     byte_valid_i,
  input  logic [7:0]               byte_data_i,
  output logic                     byte_ready_o,
  output logic                     load_busy_o,
  output logic                     load_done_o,
  output logic                     load_err_o,
  input  logic [63:0]              PC_i,
  output logic [8*INSTR_BYTES-1:0] instr_o,
  output logic                     imem_error_o
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] PC_LAST   = 64'(MEM_BYTES - INSTR_BYTES);
  localparam logic [11:0] MEM_LIMIT = 12'(MEM_BYTES);
  localparam logic [10:0] PTR_LIMIT = 11'(MEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q;
  logic [10:0] ptr_q;
  logic [10:0] cnt_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic [7:0]  mem_q [MEM_BYTES];

  // Request validation: the end address is computed one bit wider than
  // either operand so an overflowing request can never alias into range.
  logic [11:0] req_end_d;
  logic        req_bad_d;
  logic        wr_en_d;

  assign req_end_d = {2'b00, load_base_i} + {1'b0, load_len_i};
  assign req_bad_d = (load_len_i == 11'd0) || (req_end_d > MEM_LIMIT);

  // The pointer range test never fails for an accepted request; it keeps
  // the write index provably inside the array.
  assign wr_en_d = !rst_i && (state_q == S_LOAD) && byte_valid_i
                   && (ptr_q < PTR_LIMIT);

  // Loader control FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start_i) begin
            if (req_bad_d) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              ptr_q   <= {1'b0, load_base_i};
              cnt_q   <= load_len_i;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (byte_valid_i) begin
            ptr_q <= ptr_q + 11'd1;
            cnt_q <= cnt_q - 11'd1;
            if (cnt_q == 11'd1) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        S_ERR: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: no reset, so loaded programs survive a reset pulse
  always_ff @(posedge clk_i) begin
    if (wr_en_d) begin
      mem_q[ptr_q[AW-1:0]] <= byte_data_i;
    end
  end

  // Fetch window: each byte address is formed one bit wider than PC_i so
  // a window that wraps past 2^64 is seen as out of range, not as address 0.
  // Out-of-range bytes read zero through a zero index, never an
  // out-of-bounds one.
  for (genvar g = 0; g < INSTR_BYTES; g++) begin : g_win
    logic [64:0]   addr;
    logic          in_range;
    logic [AW-1:0] idx;

    assign addr     = {1'b0, PC_i} + 65'(g);
    assign in_range = (addr < 65'(MEM_BYTES));
    assign idx      = in_range ? addr[AW-1:0] : '0;
    assign instr_o[8*g +: 8] = in_range ? mem_q[idx] : 8'h00;
  end

  assign imem_error_o = (PC_i > PC_LAST) || busy_q;

  assign byte_ready_o = ready_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed sequence with randomized program bytes and stall patterns.
// The reference is a plain byte array holding what memory should contain.
// Control expectations follow from the transaction being run: idle,
// loading, the done cycle, or a rejected request.
// ---------------------------------------------------------------------------
module tb_imem_loader;
  localparam int MEM_BYTES   = 1024;
  localparam int INSTR_BYTES = 10;
  localparam int PC_LAST     = MEM_BYTES - INSTR_BYTES;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [9:0]  load_base;
  logic [10:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
  logic [63:0] PC;
  logic [79:0] instr;
  logic        imem_error;

  imem_loader #(
    .MEM_BYTES  (MEM_BYTES),
    .INSTR_BYTES(INSTR_BYTES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_start_i(load_start),
    .load_base_i (load_base),
    .load_len_i  (load_len),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_ready_o(byte_ready),
    .load_busy_o (load_busy),
    .load_done_o (load_done),
    .load_err_o  (load_err),
    .PC_i        (PC),
    .instr_o     (instr),
    .imem_error_o(imem_error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected memory image
  logic [7:0] model_mem [MEM_BYTES];

  // Optional scripted data / valid patterns consumed by run_load
  logic [7:0] fixed_q [$];
  logic       valid_q [$];
  int         glitch_at = -1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window of INSTR_BYTES bytes from pc; bytes past the end of memory are 0
  function automatic logic [79:0] exp_instr(input logic [63:0] pc);
    logic [79:0] r;
    logic [64:0] a;
    r = '0;
    for (int i = 0; i < INSTR_BYTES; i++) begin
      a = {1'b0, pc} + 65'(i);
      if (a < 65'(MEM_BYTES)) r[8*i +: 8] = model_mem[a[9:0]];
    end
    return r;
  endfunction

  task automatic chk_ctl(input string tag, input logic rdy, input logic busy,
                         input logic done, input logic err);
    chk({tag, ".ready"}, 80'(byte_ready), 80'(rdy));
    chk({tag, ".busy"},  80'(load_busy),  80'(busy));
    chk({tag, ".done"},  80'(load_done),  80'(done));
    chk({tag, ".err"},   80'(load_err),   80'(err));
  endtask

  task automatic chk_fetch(input string tag, input logic busy);
    logic exp_err;
    exp_err = (PC > 64'(PC_LAST)) || busy;
    chk({tag, ".instr"},    instr,             exp_instr(PC));
    chk({tag, ".imem_err"}, 80'(imem_error),   80'(exp_err));
  endtask

  // Run one accepted load from start to the idle cycle after DONE
  task automatic run_load(input int base, input int len, input string tag);
    int         sent;
    int         cyc;
    logic       v;
    logic [7:0] d;
    sent = 0;
    cyc  = 0;
    byte_valid = 1'b0;
    load_start = 1'b1;
    load_base  = 10'(base);
    load_len   = 11'(len);
    tick();
    load_start = 1'b0;
    while (sent < len) begin
      if (valid_q.size() > 0) v = valid_q.pop_front();
      else if (cyc > 2 * len + 20) v = 1'b1;
      else v = ($urandom_range(0, 3) != 0);
      if (v && fixed_q.size() > 0) d = fixed_q.pop_front();
      else d = 8'($urandom);
      byte_valid = v;
      byte_data  = d;
      PC         = 64'(base + sent);
      load_start = (cyc == glitch_at);
      load_base  = 10'(base ^ 'h155);
      load_len   = 11'd1;
      #1;
      chk_ctl({tag, ".load"}, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_fetch({tag, ".fetch"}, 1'b1);
      tick();
      if (v) begin
        model_mem[base + sent] = d;
        sent++;
      end
      cyc++;
    end
    byte_valid = 1'b0;
    load_start = (glitch_at >= 0);
    load_base  = 10'd0;
    load_len   = 11'd1;
    #1;
    chk_ctl({tag, ".donecyc"}, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_fetch({tag, ".donefetch"}, 1'b1);
    tick();
    load_start = 1'b0;
    PC = 64'((base > PC_LAST) ? PC_LAST : base);
    #1;
    chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_fetch({tag, ".after"}, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed time limit reached, required completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int b;
    logic [7:0] old_b2;

    rst        = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    PC         = '0;

    // Reset state
    tick();
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.imem_err", 80'(imem_error), 80'(0));

    // Reset wins over a start request in the same cycle
    load_start = 1'b1;
    load_base  = 10'd0;
    load_len   = 11'd4;
    tick();
    load_start = 1'b0;
    chk_ctl("rst_vs_start", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_ctl("rst_vs_start.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the whole memory: maximum length, end exactly at MEM_BYTES
    run_load(0, MEM_BYTES, "full");

    // Short program, no stalls
    fixed_q = '{8'h30, 8'hF2, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    valid_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_load(0, 10, "prog10");
    PC = 64'd0;
    #1;
    chk("prog10.instr_const", instr, 80'h0000_0000_0000_0008_F230);
    chk("prog10.imem_err", 80'(imem_error), 80'(0));

    // Overflowing request is rejected and writes nothing
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    load_start = 1'b1;
    load_base  = 10'd1020;
    load_len   = 11'd5;
    tick();
    chk_ctl("ovf.err", 1'b0, 1'b0, 1'b0, 1'b1);
    // Start during ERR is ignored
    load_base  = 10'd0;
    load_len   = 11'd2;
    tick();
    load_start = 1'b0;
    chk_ctl("ovf.idle", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    byte_valid = 1'b0;
    chk_ctl("ovf.stay", 1'b0, 1'b0, 1'b0, 1'b1);
    PC = 64'(PC_LAST);
    #1;
    chk_fetch("ovf.nowrite", 1'b0);
    // A valid request clears the flag and loads up to the last byte
    run_load(1019, 5, "tail");

    // Zero-length request
    load_start = 1'b1;
    load_base  = 10'd5;
    load_len   = 11'd0;
    tick();
    load_start = 1'b0;
    chk_ctl("len0.err", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_ctl("len0.sticky", 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("len0.rst_clears", 1'b0, 1'b0, 1'b0, 1'b0);

    // One byte too long
    load_start = 1'b1;
    load_base  = 10'd1;
    load_len   = 11'd1024;
    tick();
    load_start = 1'b0;
    chk_ctl("len1024_base1.err", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    run_load(1023, 1, "lastbyte");

    // Stalls: valid 1,0,0,1,0,1 for a 3-byte load
    b = $urandom_range(100, 900);
    valid_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_load(b, 3, "stall3");

    // Start pulses while busy (LOAD and DONE) are ignored
    b = $urandom_range(100, 900);
    valid_q   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    glitch_at = 1;
    run_load(b, 4, "ignore_start");
    glitch_at = -1;

    // Fetch window boundaries
    PC = 64'd1014;
    #1;
    chk_fetch("pc1014", 1'b0);
    chk("pc1014.imem_err_const", 80'(imem_error), 80'(0));
    PC = 64'd1015;
    #1;
    chk_fetch("pc1015", 1'b0);
    chk("pc1015.imem_err_const", 80'(imem_error), 80'(1));
    chk("pc1015.top_byte", 80'(instr[79:72]), 80'(0));
    PC = 64'd1023;
    #1;
    chk_fetch("pc1023", 1'b0);
    PC = 64'd1024;
    #1;
    chk("pc1024.instr", instr, 80'h0);
    PC = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("pcmax.instr", instr, 80'h0);
    chk("pcmax.imem_err", 80'(imem_error), 80'(1));
    for (int i = 0; i < 20; i++) begin
      PC = 64'($urandom_range(0, 1100));
      #1;
      chk_fetch("pcrand", 1'b0);
    end

    // Reset mid-load: 2 of 6 bytes written, then abort
    b = $urandom_range(200, 800);
    load_start = 1'b1;
    load_base  = 10'(b);
    load_len   = 11'd6;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      #1;
      chk_ctl("abort.load", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      model_mem[b + k] = byte_data;
    end
    old_b2     = model_mem[b + 2];
    rst        = 1'b1;
    byte_valid = 1'b1;
    byte_data  = ~old_b2;
    tick();
    rst        = 1'b0;
    byte_valid = 1'b0;
    chk_ctl("abort.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("abort.nodone", 1'b0, 1'b0, 1'b0, 1'b0);
    PC = 64'(b);
    #1;
    chk_fetch("abort.persist", 1'b0);
    run_load($urandom_range(0, 1000), 3, "fresh");

    // Whole-memory sweep against the expected image
    for (int p = 0; p <= PC_LAST; p += INSTR_BYTES) begin
      PC = 64'(p);
      #1;
      chk_fetch("sweep", 1'b0);
    end
    PC = 64'(PC_LAST);
    #1;
    chk_fetch("sweep.end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, size of the byte-addressed instruction memory.
REQ-002 Parameter: INSTR_BYTES, default 10, width in bytes of the fetch read window.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 load_start_i  input  1  one-cycle request to begin a load.
REQ-006 load_base_i  input  10  first byte address of the load, sampled with load_start_i.
REQ-007 load_len_i  input  11  byte count of the load, 1..MEM_BYTES, sampled with load_start_i.
REQ-008 byte_valid_i  input  1  a program byte is offered.
REQ-009 byte_data_i  input  8  the offered program byte.
REQ-010 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-011 load_busy_o  output  1  a load is in progress.
REQ-012 load_done_o  output  1  one-cycle pulse after the last byte is written.
REQ-013 load_err_o  output  1  sticky flag: last requested load was rejected.
REQ-014 PC_i  input  64  fetch address.
REQ-015 instr_o  output  80  bytes PC_i+9..PC_i+0, with byte PC_i+0 in bits [7:0].
REQ-016 imem_error_o  output  1  fetch window invalid.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE and ERR.
REQ-018 In IDLE, load_start_i with load_len_i=0 or load_base_i+load_len_i > MEM_BYTES SHALL go to ERR; no memory byte is written.
REQ-019 In IDLE, any other load_start_i SHALL go to LOAD, set the write pointer to load_base_i and the remaining count to load_len_i, and clear load_err_o.
REQ-020 byte_ready_o SHALL be 1 only in LOAD; a byte is accepted on an edge where byte_valid_i and byte_ready_o are both 1.
REQ-021 An accepted byte SHALL be written at the write pointer on that edge; the pointer then increments by 1 and the remaining count decrements by 1.
REQ-022 Acceptance with remaining count equal to 1 SHALL go to DONE; DONE lasts exactly one cycle with load_done_o=1, then returns to IDLE.
REQ-023 byte_valid_i=0 in LOAD SHALL hold state, pointer and count; stalls are unlimited.
REQ-024 ERR SHALL set load_err_o=1 and return to IDLE after one cycle; load_err_o stays 1 until the next accepted start.
REQ-025 load_start_i outside IDLE SHALL be ignored.
REQ-026 load_busy_o SHALL be 1 in LOAD and DONE.
REQ-027 The write pointer SHALL never wrap, because REQ-018 rejects any overflowing request.
REQ-028 instr_o SHALL be combinational from PC_i and memory contents; a byte written on edge N is visible on instr_o after edge N.
REQ-029 A fetch of an address written on the same edge SHALL return the old byte before that edge.
REQ-030 imem_error_o SHALL be 1 when PC_i > MEM_BYTES-INSTR_BYTES (PC_i > 1014 by default) or when load_busy_o=1.
REQ-031 When PC_i > MEM_BYTES-INSTR_BYTES, any window byte at an address >= MEM_BYTES SHALL read as 8'h00; no out-of-range array index is generated.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-033 While rst_i=1 at an edge, the block SHALL go to IDLE and clear the pointer and count to 0.
REQ-034 Reset values: byte_ready_o=0, load_busy_o=0, load_done_o=0, load_err_o=0.
REQ-035 Reset during LOAD SHALL abort the load; bytes already written remain, and no load_done_o pulse is produced.
REQ-036 Reset SHALL take priority over load_start_i and over byte acceptance in the same cycle.

Verification
REQ-037 Start with base=0, len=10; stream bytes 30,F2,08,00,00,00,00,00,00,00 with no stalls -> load_done_o pulses one cycle after the 10th acceptance; PC_i=0 gives instr_o=80'h000000000000000008F230 and imem_error_o=0.
REQ-038 Start with base=1020, len=5 -> ERR, load_err_o=1, no writes; a following start with base=1019, len=5 -> load_err_o clears and 5 bytes load.
REQ-039 Start with len=3 and byte_valid_i toggled 1,0,0,1,0,1 -> exactly 3 writes at base..base+2, and load_busy_o stays 1 through the stalls.
REQ-040 PC_i=1014 -> imem_error_o=0; PC_i=1015 -> imem_error_o=1 and instr_o[79:72]=8'h00; PC_i=64'hFFFF_FFFF_FFFF_FFFF -> imem_error_o=1 with no X on instr_o.
REQ-041 Assert rst_i after 2 of 6 bytes -> IDLE next cycle, no load_done_o, the 2 bytes persist, and a fresh start is accepted.
REQ-042 load_start_i pulsed during LOAD -> ignored, and the original pointer and count continue unchanged.
